// File: rtl/key_ex_1.sv
// key_ex_1 : AES-128 key expansion engine with round-key read port.
//
// Expands a 128-bit cipher key into 44 32-bit words (round keys 0..10)
// using an external S-box and an external Rcon table, both reached through
// request/done handshakes. Round keys can be read back at any time.
//
// Ports
//   clk                clock, rising edge
//   rst                asynchronous reset, active low
//   k_in0..k_in15      cipher key bytes, column-major (k_in0 = first byte)
//   key_en             start / continue expansion (low freezes the FSM)
//   key_done           all 11 round keys stored (sticky until reset)
//   key_rd_en, addr    round-key read request, index 0..10
//   out0..out15        registered round key, same byte order as k_in
//   s_in0..s_in3       S-box lookup addresses (RotWord of last word)
//   s_rd_en            S-box request
//   s_out0..s_out3     S-box results, s_done marks them valid
//   rcon_in            Rcon table address (round index)
//   rcon_rd_en         Rcon request
//   rcon_out           Rcon value, r_done marks it valid
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for key_en
// LOAD    | key bytes written to w[0..3], round counter set to 1
// REQ     | S-box / Rcon lookups outstanding for the current round
// COMPUTE | four new words written for the current round
// DONE    | expansion complete, no further lookups

module key_ex_1 (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] k_in0,
   input  logic [7:0] k_in1,
   input  logic [7:0] k_in2,
   input  logic [7:0] k_in3,
   input  logic [7:0] k_in4,
   input  logic [7:0] k_in5,
   input  logic [7:0] k_in6,
   input  logic [7:0] k_in7,
   input  logic [7:0] k_in8,
   input  logic [7:0] k_in9,
   input  logic [7:0] k_in10,
   input  logic [7:0] k_in11,
   input  logic [7:0] k_in12,
   input  logic [7:0] k_in13,
   input  logic [7:0] k_in14,
   input  logic [7:0] k_in15,
   input  logic       key_en,
   output logic       key_done,
   input  logic       key_rd_en,
   input  logic [3:0] addr,
   output logic [7:0] out0,
   output logic [7:0] out1,
   output logic [7:0] out2,
   output logic [7:0] out3,
   output logic [7:0] out4,
   output logic [7:0] out5,
   output logic [7:0] out6,
   output logic [7:0] out7,
   output logic [7:0] out8,
   output logic [7:0] out9,
   output logic [7:0] out10,
   output logic [7:0] out11,
   output logic [7:0] out12,
   output logic [7:0] out13,
   output logic [7:0] out14,
   output logic [7:0] out15,
   output logic [7:0] s_in0,
   output logic [7:0] s_in1,
   output logic [7:0] s_in2,
   output logic [7:0] s_in3,
   output logic       s_rd_en,
   input  logic [7:0] s_out0,
   input  logic [7:0] s_out1,
   input  logic [7:0] s_out2,
   input  logic [7:0] s_out3,
   input  logic       s_done,
   output logic [7:0] rcon_in,
   output logic       rcon_rd_en,
   input  logic [7:0] rcon_out,
   input  logic       r_done
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_REQ     = 3'd2,
      ST_COMPUTE = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  rnd_q, rnd_d;
   logic [31:0] sub_q, sub_d;
   logic        sub_got_q, sub_got_d;
   logic [7:0]  rc_q, rc_d;
   logic        rc_got_q, rc_got_d;
   logic        load_en;
   logic        comp_en;
   logic [31:0] s_addr_w;

   logic [31:0]  w_q [0:43];
   logic [127:0] out_q;

   // Word address helpers; the round index is clamped into 1..10 so the
   // array is never indexed out of range while idle or done.
   logic [3:0]  blk;
   logic [5:0]  base;
   logic [31:0] last_w;
   logic [31:0] t_w;
   logic [31:0] nw0, nw1, nw2, nw3;

   assign blk    = (rnd_q == 4'd0 || rnd_q > 4'd10) ? 4'd1 : rnd_q;
   assign base   = {blk, 2'b00};
   assign last_w = w_q[base - 6'd1];
   assign t_w    = sub_q ^ {rc_q, 24'h000000};
   assign nw0    = w_q[base - 6'd4] ^ t_w;
   assign nw1    = w_q[base - 6'd3] ^ nw0;
   assign nw2    = w_q[base - 6'd2] ^ nw1;
   assign nw3    = w_q[base - 6'd1] ^ nw2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         rnd_q     <= 4'd0;
         sub_q     <= '0;
         sub_got_q <= 1'b0;
         rc_q      <= '0;
         rc_got_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         rnd_q     <= rnd_d;
         sub_q     <= sub_d;
         sub_got_q <= sub_got_d;
         rc_q      <= rc_d;
         rc_got_q  <= rc_got_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rnd_d      = rnd_q;
      sub_d      = sub_q;
      sub_got_d  = sub_got_q;
      rc_d       = rc_q;
      rc_got_d   = rc_got_q;
      load_en    = 1'b0;
      comp_en    = 1'b0;
      s_rd_en    = 1'b0;
      rcon_rd_en = 1'b0;
      s_addr_w   = '0;
      rcon_in    = '0;
      key_done   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (key_en) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (key_en) begin
               load_en   = 1'b1;
               rnd_d     = 4'd1;
               sub_got_d = 1'b0;
               rc_got_d  = 1'b0;
               state_d   = ST_REQ;
            end
         end
         ST_REQ: begin
            // Each request drops once its own result has been latched;
            // addresses stay put for the whole REQ stay.
            s_rd_en    = ~sub_got_q;
            rcon_rd_en = ~rc_got_q;
            s_addr_w   = {last_w[23:0], last_w[31:24]};
            rcon_in    = {4'd0, rnd_q};
            if (key_en) begin
               if (!sub_got_q && s_done) begin
                  sub_d     = {s_out0, s_out1, s_out2, s_out3};
                  sub_got_d = 1'b1;
               end
               if (!rc_got_q && r_done) begin
                  rc_d     = rcon_out;
                  rc_got_d = 1'b1;
               end
               if ((sub_got_q || s_done) && (rc_got_q || r_done))
                  state_d = ST_COMPUTE;
            end
         end
         ST_COMPUTE: begin
            if (key_en) begin
               comp_en   = 1'b1;
               sub_got_d = 1'b0;
               rc_got_d  = 1'b0;
               if (rnd_q < 4'd10) begin
                  rnd_d   = rnd_q + 4'd1;
                  state_d = ST_REQ;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            key_done = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign s_in0 = s_addr_w[31:24];
   assign s_in1 = s_addr_w[23:16];
   assign s_in2 = s_addr_w[15:8];
   assign s_in3 = s_addr_w[7:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int j = 0; j < 44; j++) w_q[j] <= '0;
      end else if (load_en) begin
         w_q[0] <= {k_in0,  k_in1,  k_in2,  k_in3};
         w_q[1] <= {k_in4,  k_in5,  k_in6,  k_in7};
         w_q[2] <= {k_in8,  k_in9,  k_in10, k_in11};
         w_q[3] <= {k_in12, k_in13, k_in14, k_in15};
      end else if (comp_en) begin
         w_q[base]         <= nw0;
         w_q[base + 6'd1]  <= nw1;
         w_q[base + 6'd2]  <= nw2;
         w_q[base + 6'd3]  <= nw3;
      end
   end

   logic [3:0] raddr;
   logic [5:0] rbase;
   assign raddr = (addr > 4'd10) ? 4'd0 : addr;
   assign rbase = {raddr, 2'b00};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_q <= '0;
      end else if (key_rd_en) begin
         if (addr > 4'd10)
            out_q <= '0;
         else
            out_q <= {w_q[rbase], w_q[rbase + 6'd1], w_q[rbase + 6'd2], w_q[rbase + 6'd3]};
      end
   end

   assign out0  = out_q[127:120];
   assign out1  = out_q[119:112];
   assign out2  = out_q[111:104];
   assign out3  = out_q[103:96];
   assign out4  = out_q[95:88];
   assign out5  = out_q[87:80];
   assign out6  = out_q[79:72];
   assign out7  = out_q[71:64];
   assign out8  = out_q[63:56];
   assign out9  = out_q[55:48];
   assign out10 = out_q[47:40];
   assign out11 = out_q[39:32];
   assign out12 = out_q[31:24];
   assign out13 = out_q[23:16];
   assign out14 = out_q[15:8];
   assign out15 = out_q[7:0];

endmodule

// File: tb/tb_key_ex_1.sv
module tb_key_ex_1;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] kb [16];
   logic       key_en;
   logic       key_done;
   logic       key_rd_en;
   logic [3:0] addr;
   logic [7:0] ob [16];
   logic [7:0] sin [4];
   logic       s_rd_en;
   logic [7:0] sout [4];
   logic       s_done;
   logic [7:0] rcon_in;
   logic       rcon_rd_en;
   logic [7:0] rcon_out;
   logic       r_done;

   int checks = 0;
   int failures = 0;
   int stab_err = 0;
   int s_dly = 0;
   int r_dly = 0;
   int s_cnt, r_cnt;
   logic [127:0] exp_rk [11];

   always #5 clk = ~clk;

   key_ex_1 dut (
      .clk(clk), .rst(rst),
      .k_in0(kb[0]), .k_in1(kb[1]), .k_in2(kb[2]), .k_in3(kb[3]),
      .k_in4(kb[4]), .k_in5(kb[5]), .k_in6(kb[6]), .k_in7(kb[7]),
      .k_in8(kb[8]), .k_in9(kb[9]), .k_in10(kb[10]), .k_in11(kb[11]),
      .k_in12(kb[12]), .k_in13(kb[13]), .k_in14(kb[14]), .k_in15(kb[15]),
      .key_en(key_en), .key_done(key_done),
      .key_rd_en(key_rd_en), .addr(addr),
      .out0(ob[0]), .out1(ob[1]), .out2(ob[2]), .out3(ob[3]),
      .out4(ob[4]), .out5(ob[5]), .out6(ob[6]), .out7(ob[7]),
      .out8(ob[8]), .out9(ob[9]), .out10(ob[10]), .out11(ob[11]),
      .out12(ob[12]), .out13(ob[13]), .out14(ob[14]), .out15(ob[15]),
      .s_in0(sin[0]), .s_in1(sin[1]), .s_in2(sin[2]), .s_in3(sin[3]),
      .s_rd_en(s_rd_en),
      .s_out0(sout[0]), .s_out1(sout[1]), .s_out2(sout[2]), .s_out3(sout[3]),
      .s_done(s_done),
      .rcon_in(rcon_in), .rcon_rd_en(rcon_rd_en),
      .rcon_out(rcon_out), .r_done(r_done)
   );

   logic [127:0] rd_val;
   logic [31:0]  sin_w;
   always_comb begin
      rd_val = {ob[0], ob[1], ob[2], ob[3], ob[4], ob[5], ob[6], ob[7],
                ob[8], ob[9], ob[10], ob[11], ob[12], ob[13], ob[14], ob[15]};
      sin_w  = {sin[0], sin[1], sin[2], sin[3]};
   end

   // GF(2^8) helpers: S-box derived from the field inverse plus affine map.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int k = 0; k < 8; k++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] r = 8'h01;
      for (int k = 0; k < 254; k++) r = gmul(r, x);
      return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] rcon_f(input int i);
      logic [7:0] r = 8'h01;
      for (int k = 1; k < i; k++) r = gmul(r, 8'h02);
      return r;
   endfunction

   // Textbook AES-128 key schedule.
   task automatic expand(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      for (int j = 0; j < 4; j++) w[j] = key[127 - 32*j -: 32];
      for (int j = 4; j < 44; j++) begin
         t = w[j-1];
         if (j % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
            t = t ^ {rcon_f(j/4), 24'h000000};
         end
         w[j] = w[j-4] ^ t;
      end
      for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // External S-box / Rcon responders; done stays high while the request is.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         s_cnt <= 0; s_done <= 1'b0;
         for (int k = 0; k < 4; k++) sout[k] <= 8'h00;
      end else if (!s_rd_en) begin
         s_cnt <= 0; s_done <= 1'b0;
      end else if (s_cnt >= s_dly) begin
         s_done <= 1'b1;
         for (int k = 0; k < 4; k++) sout[k] <= sbox(sin[k]);
      end else begin
         s_cnt <= s_cnt + 1;
      end
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= 0; r_done <= 1'b0; rcon_out <= 8'h00;
      end else if (!rcon_rd_en) begin
         r_cnt <= 0; r_done <= 1'b0;
      end else if (r_cnt >= r_dly) begin
         r_done <= 1'b1;
         rcon_out <= rcon_f(int'(rcon_in));
      end else begin
         r_cnt <= r_cnt + 1;
      end
   end

   // A pending request must stay asserted with a stable address until done.
   logic        p_sreq = 1'b0, p_sdone = 1'b0, p_rreq = 1'b0, p_rdone = 1'b0;
   logic [31:0] p_sin = '0;
   logic [7:0]  p_rin = '0;
   always @(negedge clk) begin
      if (rst) begin
         if (p_sreq && !p_sdone && (!s_rd_en || sin_w != p_sin)) stab_err++;
         if (p_rreq && !p_rdone && (!rcon_rd_en || rcon_in != p_rin)) stab_err++;
         p_sreq = s_rd_en; p_sdone = s_done; p_sin = sin_w;
         p_rreq = rcon_rd_en; p_rdone = r_done; p_rin = rcon_in;
      end else begin
         p_sreq = 1'b0; p_rreq = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_key(input logic [127:0] k);
      for (int j = 0; j < 16; j++) kb[j] = k[127 - 8*j -: 8];
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; key_en = 1'b0; key_rd_en = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic read_rk(input int a, output logic [127:0] v);
      addr = a[3:0]; key_rd_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      key_rd_en = 1'b0;
      v = rd_val;
   endtask

   task automatic wait_done(input string tag);
      for (int c = 0; c < 1000 && !key_done; c++) @(negedge clk);
      chk({tag, "_done"}, {127'd0, key_done}, 128'd1);
   endtask

   task automatic wait_rcon(input string tag, input int i);
      for (int c = 0; c < 500 && !(rcon_rd_en && rcon_in == i[7:0]); c++) @(negedge clk);
      chk({tag, "_reach"}, {127'd0, rcon_rd_en}, 128'd1);
   endtask

   task automatic run_key(input string tag, input logic [127:0] key, input int sd, input int rdl);
      s_dly = sd; r_dly = rdl;
      set_key(key);
      key_en = 1'b1;
      wait_done(tag);
      key_en = 1'b0;
   endtask

   task automatic check_all(input string tag, input logic [127:0] key);
      logic [127:0] v;
      expand(key);
      for (int r = 0; r < 11; r++) begin
         read_rk(r, v);
         chk($sformatf("%s_rk%0d", tag, r), v, exp_rk[r]);
      end
   endtask

   localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY_Z = 128'h0;

   initial begin
      logic [127:0] v, hold_v, rk;
      rst = 1'b0; key_en = 1'b0; key_rd_en = 1'b0; addr = 4'd0;
      set_key(KEY_A);
      repeat (3) @(negedge clk);
      chk("rst_key_done", {127'd0, key_done}, 128'd0);
      chk("rst_reqs", {126'd0, s_rd_en, rcon_rd_en}, 128'd0);
      chk("rst_s_in", {96'd0, sin_w}, 128'd0);
      chk("rst_rcon_in", {120'd0, rcon_in}, 128'd0);
      chk("rst_out", rd_val, 128'd0);
      rst = 1'b1;
      @(negedge clk);
      read_rk(0, v);
      chk("pre_read_zero", v, 128'd0);

      // Reference key, immediate responders.
      run_key("a0", KEY_A, 0, 0);
      read_rk(1, v);  chk("a0_fips_rk1", v, 128'ha0fafe1788542cb123a339392a6c7605);
      read_rk(10, v); chk("a0_fips_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      check_all("a0", KEY_A);
      chk("a0_stable", stab_err, 0);

      // Read port boundaries and hold after DONE.
      read_rk(1, hold_v);
      read_rk(11, v); chk("addr11_zero", v, 128'd0);
      read_rk(15, v); chk("addr15_zero", v, 128'd0);
      read_rk(1, hold_v);
      key_rd_en = 1'b0;
      for (int a = 2; a < 8; a++) begin addr = a[3:0]; @(negedge clk); end
      chk("rd_hold", rd_val, hold_v);
      key_en = 1'b1;
      repeat (3) @(negedge clk);
      key_en = 1'b0;
      repeat (2) @(negedge clk);
      chk("done_sticky", {125'd0, key_done, s_rd_en, rcon_rd_en}, 128'd4);

      // Delayed S-box, then delayed Rcon.
      do_reset();
      run_key("sdly", KEY_A, 3, 0);
      check_all("sdly", KEY_A);
      do_reset();
      run_key("rdly", KEY_A, 0, 3);
      check_all("rdly", KEY_A);
      chk("dly_stable", stab_err, 0);

      // Reset during round 5, then all-zero key.
      do_reset();
      s_dly = 0; r_dly = 0;
      read_rk(0, v);
      run_key("pre", KEY_A, 0, 0);
      read_rk(3, v);
      do_reset();
      set_key(KEY_A);
      key_en = 1'b1;
      wait_rcon("mid", 5);
      rst = 1'b0;
      #2;
      chk("mid_rst_state", {125'd0, key_done, s_rd_en, rcon_rd_en}, 128'd0);
      chk("mid_rst_out", rd_val, 128'd0);
      key_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_key("z", KEY_Z, 0, 0);
      read_rk(0, v);  chk("z_rk0", v, 128'd0);
      read_rk(1, v);  chk("z_rk1", v, 128'h62636363626363636263636362636363);
      read_rk(10, v); chk("z_rk10", v, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

      // key_en pause mid-expansion.
      do_reset();
      set_key(KEY_A);
      key_en = 1'b1;
      wait_rcon("pause", 3);
      key_en = 1'b0;
      repeat (4) @(negedge clk);
      chk("pause_frozen", {119'd0, key_done, rcon_rd_en, rcon_in}, {119'd0, 1'b0, 1'b1, 8'd3});
      key_en = 1'b1;
      wait_done("pause");
      key_en = 1'b0;
      read_rk(10, v); chk("pause_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      check_all("pause", KEY_A);

      // Random keys and latencies against the reference schedule.
      for (int n = 0; n < 3; n++) begin
         rk = {$urandom, $urandom, $urandom, $urandom};
         do_reset();
         run_key($sformatf("rnd%0d", n), rk, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         check_all($sformatf("rnd%0d", n), rk);
      end
      chk("final_stable", stab_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/key_ex_1.md
KEY_EX_1 -- requirements
Module: key_ex_1

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 k_in0..k_in15  input  8 each  cipher key; k_in0 is the first key byte, column-major (byte j = word j/4, row j%4).
REQ-005 key_en  input  1  high starts or continues expansion.
REQ-006 key_done  output  1  high once all 11 round keys are stored.
REQ-007 key_rd_en  input  1  round-key read enable.
REQ-008 addr  input  4  round-key index, 0..10.
REQ-009 out0..out15  output  8 each  selected round key, same byte order as k_in.
REQ-010 s_in0..s_in3  output  8 each  S-box lookup addresses.
REQ-011 s_rd_en  output  1  S-box request.
REQ-012 s_out0..s_out3  input  8 each  S-box results.
REQ-013 s_done  input  1  S-box results valid.
REQ-014 rcon_in  output  8  Rcon table address.
REQ-015 rcon_rd_en  output  1  Rcon request.
REQ-016 rcon_out  input  8  Rcon value.
REQ-017 r_done  input  1  Rcon value valid.

Function
REQ-018 SHALL implement AES-128 key expansion into internal storage of 44 32-bit words w[0..43] (rounds 0..10).
REQ-019 SHALL use FSM states IDLE, LOAD, REQ, COMPUTE, DONE.
REQ-020 IDLE: on key_en=1, go to LOAD; otherwise stay in IDLE.
REQ-021 LOAD (1 cycle): store k_in0..15 as w[0..3], set round counter i=1, go to REQ.
REQ-022 REQ: drive s_in0..3 = RotWord(w[4i-1]), i.e. bytes {b1,b2,b3,b0} of the word.
REQ-023 REQ: drive rcon_in = i, so the external table returns 0x01,0x02,0x04,0x08,0x10,0x20,0x40,0x80,0x1B,0x36 for i=1..10.
REQ-024 REQ: assert s_rd_en and rcon_rd_en, and hold them and the addresses stable until the corresponding done is sampled high.
REQ-025 REQ: latch s_out0..3 on the edge s_done is high and rcon_out on the edge r_done is high; the two may arrive in different cycles in either order; go to COMPUTE once both are latched.
REQ-026 COMPUTE (1 cycle): deassert both requests.
REQ-027 COMPUTE: w[4i] = w[4i-4] ^ {sub0^rcon, sub1, sub2, sub3}; w[4i+k] = w[4i+k-4] ^ w[4i+k-1] for k=1..3.
REQ-028 COMPUTE: if i<10, increment i and return to REQ; otherwise go to DONE.
REQ-029 DONE: key_done=1 and stays 1 until reset; key_en is ignored; no further S-box/Rcon requests are issued.
REQ-030 key_en dropping low before DONE SHALL freeze the FSM in its current state (requests held) until key_en returns high.
REQ-031 Read port: on each rising edge with key_rd_en=1, out0..15 <= round key addr (w[4addr..4addr+3]), one-cycle latency.
REQ-032 Read port: addr>10 SHALL yield all-zero out0..15.
REQ-033 Read port: key_rd_en=0 SHALL hold out0..15.
REQ-034 Read port: reads are permitted before DONE and return current storage contents (zero if not yet written).
REQ-035 All XOR is bytewise 8-bit; there is no carry or width growth.

Reset
REQ-036 rst=0 SHALL immediately force state IDLE, i=0, storage all zero, and key_done, s_rd_en, rcon_rd_en, s_in0..3, rcon_in and out0..15 all 0.
REQ-037 Reset mid-expansion SHALL abort it; a new key_en after rst returns high restarts from LOAD with the then-current k_in.

Verification
REQ-038 Key 2b7e151628aed2a6abf7158809cf4f3c, bench S-box/Rcon models answering in 1 cycle, key_en=1 -> key_done=1; addr=1 reads a0fafe1788542cb123a339392a6c7605; addr=10 reads d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-039 All-zero key -> addr=0 reads 00..00; addr=1 reads 62636363626363636263636362636363; addr=10 reads b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-040 Same key as REQ-038 with s_done delayed 3 cycles and r_done immediate (then reversed) -> identical round keys; s_in0..3 and rcon_in stable throughout each wait.
REQ-041 rst pulsed low during round 5 of expansion -> key_done=0, out0..15=0, requests low; re-run with the all-zero key -> REQ-039 results.
REQ-042 After DONE: addr=11 with key_rd_en=1 -> out0..15=0 next cycle; key_rd_en=0 while addr changes -> outputs unchanged.
REQ-043 key_en low for 4 cycles mid-expansion -> expansion resumes; final keys match REQ-038.
